serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. One shared ha_cell (sum=a^b, cout=a&b) is time-multiplexed
//  to add two WIDTH-bit operands plus carry-in, LSB first, 2 cycles per bit.
//  Used where area beats latency; sits between a requester (start/done handshake) and a
//  result consumer. The only arithmetic resource is the single half-adder cell.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst_n  in   1      synchronous reset, active-low (sampled on clk rising edge only)
//  start  in   1      request; accepted only when state==IDLE
//  op_a   in   WIDTH  operand A, captured on the accepting edge
//  op_b   in   WIDTH  operand B, captured on the accepting edge
//  cin    in   1      carry-in, captured on the accepting edge
//  busy   out  1      high in PH0/PH1
//  done   out  1      high for exactly one cycle (state DONE)
//  sum    out  WIDTH  result; held from DONE entry until the next DONE entry
//  cout   out  1      carry-out; same hold rule as sum
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; bit index, p/g, carry and shift regs = 0.
//  - States: IDLE -> PH0 -> PH1 -> (PH0 next bit | DONE) -> IDLE.
//  - IDLE: start=1 at edge E0 -> latch op_a, op_b, cin into carry; idx=0; go to PH0.
//    start=0 -> stay.
//  - PH0 (bit idx): ha_cell inputs = (a[idx], b[idx]); register p<=ha.sum, g<=ha.cout; go to PH1.
//  - PH1: ha_cell inputs = (p, carry); shift ha.sum into MSB of the result shift reg
//    (shift right); carry <= g | ha.cout.
//    idx==WIDTH-1 -> DONE, else idx+1 -> PH0.
//  - DONE entry edge: sum <= completed shift reg, cout <= final carry; done=1 for one cycle; then IDLE.
//  - Timing: if start is accepted at edge E0, the cycle after edge E0+2*WIDTH is DONE.
//    Minimum spacing between accepting edges is 2*WIDTH+2.
//  - start in PH0/PH1/DONE is ignored, with no queueing. Operands may change freely after E0.
//  - Width rule: result = (op_a + op_b + cin) mod 2^WIDTH; cout = bit WIDTH of that sum.
//  - rst_n low at any edge (mid-operation included): immediate reset values, operation
//    discarded, no done pulse.
//  - rst_n low and start high at the same edge: reset wins.
//  - busy and done are never high together. Outputs are registered; there are no
//    combinational paths from inputs to outputs.
// STRUCTURE
//  - Package serial_add_pkg: state localparams IDLE=2'd0, PH0=2'd1, PH1=2'd2, DONE=2'd3;
//    IDX_W = $clog2(WIDTH), minimum 1.
//  - Sub-module: ha_cell (a, b -> sum, cout), instantiated exactly once.
//    Its input mux is driven by the FSM.
//  - Remaining logic in this module: FSM, idx counter, operand regs, p/g/carry regs,
//    result shift reg.
// TESTING (WIDTH=8 unless noted)
//  1. rst_n=0 for 2 edges -> busy=0, done=0, sum=8'h00, cout=0; start=0 afterwards -> stays IDLE.
//  2. a=8'h3C, b=8'h0F, cin=0, start at E0 -> busy=1 for 16 cycles; done=1 in the cycle after
//     E0+16 only; sum=8'h4B, cout=0.
//  3. a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
//     a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4. Start 3C+0F, then pulse start with a=8'h01, b=8'h01 during PH1 of bit 2
//     -> ignored; result 8'h4B, single done pulse.
//  5. rst_n=0 at PH0 of bit 3 -> next cycle IDLE with reset outputs, no done.
//     New op 8'h10+8'h20 -> sum=8'h30.
//  6. start held high continuously with 8'h80+8'h80 -> accepting edges 18 apart, done every 18
//     cycles, sum=8'h00, cout=1. Repeat with WIDTH=1: 1+1+cin1 -> sum=1, cout=1, done 2 cycles
//     after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit-index width for a given operand width, never narrower than 1.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Single half-adder cell: the only arithmetic resource of the serial adder.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one half-adder cell time-shared over two
// phases per bit (PH0: a^b / a&b, PH1: propagate into running carry).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned IDX_W = idx_width(WIDTH);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, shreg, shreg_nx;
  logic             p, g, carry, carry_nx;
  logic             ha_a, ha_b, ha_sum, ha_cout;
  logic             last_bit;

  ha_cell u_ha (
    .a    (ha_a),
    .b    (ha_b),
    .sum  (ha_sum),
    .cout (ha_cout)
  );

  assign last_bit = (idx == IDX_W'(WIDTH - 1));
  assign carry_nx = g | ha_cout;

  // LSB-first result: each new bit enters at the MSB and the register shifts right.
  always_comb begin
    shreg_nx            = shreg >> 1;
    shreg_nx[WIDTH-1]   = ha_sum;
  end

  always_comb begin
    ha_a = 1'b0;
    ha_b = 1'b0;
    case (state)
      PH0: begin
        ha_a = a_q[idx];
        ha_b = b_q[idx];
      end
      PH1: begin
        ha_a = p;
        ha_b = carry;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PH0;
      PH0:     state_nx = PH1;
      PH1:     state_nx = last_bit ? DONE : PH0;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      shreg <= '0;
      p     <= 1'b0;
      g     <= 1'b0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          carry <= cin;
          idx   <= '0;
        end
        PH0: begin
          p <= ha_sum;
          g <= ha_cout;
        end
        PH1: begin
          shreg <= shreg_nx;
          carry <= carry_nx;
          if (last_bit) begin
            sum  <= shreg_nx;
            cout <= carry_nx;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == PH0) || (state == PH1);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .op_a  (a1),
    .op_b  (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle: busy=%0b done=%0b required idle within 100 cycles", busy, done);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    wait_idle();
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Samples n negedges after the accepting edge; optional start (1) or reset (2) pulse.
  task automatic observe(input int n, input int inj_at, input int inj_kind,
                         output int done_at, output int busy_cnt, output int done_cnt,
                         output logic [W-1:0] s, output logic c);
    done_at  = 0;
    busy_cnt = 0;
    done_cnt = 0;
    s        = sum;
    c        = cout;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      s = sum;
      c = cout;
      if (i == inj_at) begin
        if (inj_kind == 1) begin
          start = 1'b1;
          op_a  = 8'h01;
          op_b  = 8'h01;
        end else if (inj_kind == 2) begin
          rst_n = 1'b0;
        end
      end else if (i == inj_at + 1) begin
        start = 1'b0;
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
    if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum: got %h want 00", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %0b want 0", cout); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_stay_idle: busy=%0b done=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    int da, bc, dc;
    logic [W-1:0] s;
    logic c;
    launch(8'h3C, 8'h0F, 1'b0);
    observe(2 * W + 3, 0, 0, da, bc, dc, s, c);
    checks += 5;
    if (da !== 2 * W + 1) begin failures++; $display("FAIL basic_done_at: got %0d want %0d", da, 2 * W + 1); end
    if (bc !== 2 * W) begin failures++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, 2 * W); end
    if (dc !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    if (s !== 8'h4B) begin failures++; $display("FAIL basic_sum: got %h want 4b", s); end
    if (c !== 1'b0) begin failures++; $display("FAIL basic_cout: got %0b want 0", c); end
  endtask

  task automatic test_carry();
    logic [W-1:0] av [2] = '{8'hFF, 8'hFF};
    logic [W-1:0] bv [2] = '{8'h00, 8'hFF};
    logic [W-1:0] sv [2] = '{8'h00, 8'hFF};
    int da, bc, dc;
    logic [W-1:0] s;
    logic c;
    for (int k = 0; k < 2; k++) begin
      launch(av[k], bv[k], 1'b1);
      observe(2 * W + 2, 0, 0, da, bc, dc, s, c);
      checks += 2;
      if (s !== sv[k]) begin failures++; $display("FAIL carry_sum[%0d]: got %h want %h", k, s, sv[k]); end
      if (c !== 1'b1) begin failures++; $display("FAIL carry_cout[%0d]: got %0b want 1", k, c); end
    end
  endtask

  task automatic test_random();
    int da, bc, dc;
    logic [W-1:0] s, a, b;
    logic c, ci;
    logic [W:0] exp_v;
    for (int k = 0; k < 20; k++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      ci    = 1'($urandom);
      exp_v = ref_add(a, b, ci);
      launch(a, b, ci);
      observe(2 * W + 2, 0, 0, da, bc, dc, s, c);
      checks += 3;
      if (s !== exp_v[W-1:0]) begin failures++; $display("FAIL random_sum: %h+%h+%0b got %h want %h", a, b, ci, s, exp_v[W-1:0]); end
      if (c !== exp_v[W]) begin failures++; $display("FAIL random_cout: %h+%h+%0b got %0b want %0b", a, b, ci, c, exp_v[W]); end
      if (da !== 2 * W + 1) begin failures++; $display("FAIL random_done_at: got %0d want %0d", da, 2 * W + 1); end
    end
  endtask

  task automatic test_ignore_start();
    int da, bc, dc;
    logic [W-1:0] s;
    logic c;
    launch(8'h3C, 8'h0F, 1'b0);
    observe(2 * W + 4, 6, 1, da, bc, dc, s, c);
    checks += 4;
    if (dc !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d want 1", dc); end
    if (da !== 2 * W + 1) begin failures++; $display("FAIL ignore_done_at: got %0d want %0d", da, 2 * W + 1); end
    if (bc !== 2 * W) begin failures++; $display("FAIL ignore_busy_cycles: got %0d want %0d", bc, 2 * W); end
    if (s !== 8'h4B) begin failures++; $display("FAIL ignore_sum: got %h want 4b", s); end
  endtask

  task automatic test_reset_midop();
    int da, bc, dc;
    logic [W-1:0] s;
    logic c;
    launch(8'h55, 8'hAA, 1'b1);
    observe(2 * W + 4, 7, 2, da, bc, dc, s, c);
    checks += 4;
    if (dc !== 0) begin failures++; $display("FAIL midreset_done_count: got %0d want 0", dc); end
    if (bc !== 7) begin failures++; $display("FAIL midreset_busy_cycles: got %0d want 7", bc); end
    if (s !== 8'h00) begin failures++; $display("FAIL midreset_sum: got %h want 00", s); end
    if (c !== 1'b0) begin failures++; $display("FAIL midreset_cout: got %0b want 0", c); end
    launch(8'h10, 8'h20, 1'b0);
    observe(2 * W + 2, 0, 0, da, bc, dc, s, c);
    checks += 2;
    if (s !== 8'h30) begin failures++; $display("FAIL midreset_next_sum: got %h want 30", s); end
    if (c !== 1'b0) begin failures++; $display("FAIL midreset_next_cout: got %0b want 0", c); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    logic [W-1:0] s;
    logic c;
    wait_idle();
    op_a  = 8'h80;
    op_b  = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    s = '0;
    c = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      @(negedge clk);
      if (done) begin
        q.push_back(i);
        s = sum;
        c = cout;
      end
    end
    start = 1'b0;
    checks += 3;
    if (q.size() !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d want 3", q.size()); end
    if (s !== 8'h00) begin failures++; $display("FAIL b2b_sum: got %h want 00", s); end
    if (c !== 1'b1) begin failures++; $display("FAIL b2b_cout: got %0b want 1", c); end
    for (int k = 0; k < q.size() && k < 3; k++) begin
      checks++;
      if (q[k] !== 17 + 18 * k) begin failures++; $display("FAIL b2b_done_at[%0d]: got %0d want %0d", k, q[k], 17 + 18 * k); end
    end
  endtask

  task automatic test_width1();
    int da, bc;
    logic s, c;
    logic [1:0] exp_v;
    for (int k = 7; k >= 0; k--) begin
      a1     = k[2];
      b1     = k[1];
      cin1   = k[0];
      exp_v  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      da = 0;
      bc = 0;
      s  = 1'b0;
      c  = 1'b0;
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        if (busy1) bc++;
        if (done1 && da == 0) da = i;
        s = sum1;
        c = cout1;
      end
      checks += 2;
      if (s !== exp_v[0] || c !== exp_v[1]) begin
        failures++;
        $display("FAIL w1_result[%0d]: got sum=%0b cout=%0b want %0b/%0b", k, s, c, exp_v[0], exp_v[1]);
      end
      if (da !== 3 || bc !== 2) begin
        failures++;
        $display("FAIL w1_timing[%0d]: done_at=%0d busy=%0d want 3/2", k, da, bc);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
